sr4094_loader: RTL and testbench
================================

SR4094_LOADER -- requirements
Module: sr4094_loader

Interface
REQ-001 Parameter NBITS, default 24, SHALL set the bit length of the 4094 chain (3 devices); legal range 8..64.
REQ-002 Parameter DIV, default 4, SHALL set clk cycles per sr_clk half-period; legal range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: system clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: load request; sampled only while busy=0.
REQ-007 Port data, input, NBITS: word to load; bit NBITS-1 is shifted first.
REQ-008 Port busy, output, 1: high while a load is in progress.
REQ-009 Port done, output, 1: single-cycle pulse at the end of a load.
REQ-010 Port rdata, output, NBITS: previous chain contents captured from sr_miso during the last load.
REQ-011 Port sr_clk, output, 1: 4094 shift clock (GLB_4094_CLK).
REQ-012 Port sr_data, output, 1: 4094 serial data (GLB_4094_DATA).
REQ-013 Port sr_strobe, output, 1: 4094 strobe/latch.
REQ-014 Port sr_oe, output, 1: 4094 output enable (GLB_4094_OE).
REQ-015 Port sr_miso, input, 1: QS serial output of the last 4094 in the chain.

Function
REQ-016 States SHALL be IDLE, SHIFT_LO, SHIFT_HI, STROBE, DONE.
REQ-017 In IDLE with start=1, the block SHALL latch data into a shift register and enter SHIFT_LO in the next cycle with busy=1, sr_clk=0, sr_data=data[NBITS-1].
REQ-018 SHIFT_LO SHALL last DIV cycles with sr_clk=0, then go to SHIFT_HI.
REQ-019 SHIFT_HI SHALL last DIV cycles with sr_clk=1; sr_data SHALL stay stable through both phases of a bit.
REQ-020 On the cycle of entry to SHIFT_HI, sr_miso SHALL be shifted into a capture register at the LSB.
REQ-021 On leaving SHIFT_HI, a bit counter SHALL increment. If it is below NBITS, the block SHALL return to SHIFT_LO with the next bit on sr_data. Otherwise it SHALL go to STROBE with sr_clk=0.
REQ-022 STROBE SHALL hold sr_strobe=1 for DIV cycles; sr_data SHALL be 0 there and in IDLE.
REQ-023 DONE SHALL last one cycle with done=1, busy=0, and rdata updated from the capture register. The block SHALL then be in IDLE.
REQ-024 busy SHALL be high for exactly 2*DIV*NBITS + DIV cycles per load.
REQ-025 start while busy=1 SHALL be ignored with no queuing. start in the DONE cycle SHALL be ignored; the next accept is in IDLE.
REQ-026 Changes on data after acceptance SHALL NOT affect the load in progress.
REQ-027 sr_oe SHALL be 0 from reset until the first DONE, then 1 until the next reset, so the chain outputs stay disabled until it holds defined contents.
REQ-028 The divide counter SHALL be sized ceil(log2(DIV+1)) and the bit counter ceil(log2(NBITS+1)); neither SHALL wrap inside a load.

Reset
REQ-029 While rst=1: state=IDLE, busy=0, done=0, sr_clk=0, sr_data=0, sr_strobe=0, sr_oe=0, rdata=0, all counters=0.
REQ-030 rst asserted mid-load SHALL abort the load in the next cycle with no strobe pulse and no done pulse; the chain latches SHALL keep their prior contents.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification (NBITS=8, DIV=2)
REQ-032 Start with data=8'hA5 -> sr_data sequence 1,0,1,0,0,1,0,1; 8 sr_clk rising edges, each 2 cycles high; busy high 34 cycles; sr_strobe high 2 cycles; one done pulse; sr_oe rises with done.
REQ-033 Chain model preloaded with 8'h3C drives sr_miso, then start with data=8'hFF -> rdata=8'h3C at done; second load with 8'h00 -> rdata=8'hFF.
REQ-034 Start pulsed at cycles 5 and 20 of a load, and in the DONE cycle -> no change to the sequence, and exactly one done pulse.
REQ-035 rst asserted at cycle 10 of a load -> next cycle all outputs are at reset values; no sr_strobe; sr_oe=0; a following start with 8'h81 completes normally.
REQ-036 data changed from 8'hA5 to 8'h5A one cycle after accept -> shifted sequence still 8'hA5.

Source files
------------

// File: rtl/sr4094_loader.sv
// sr4094_loader: serial loader for a daisy-chained 4094 shift/latch chain.
// Shifts a word out MSB first, captures the old chain contents, then strobes.
module sr4094_loader #(
    parameter int NBITS = 24,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rdata,
    output logic             sr_clk,
    output logic             sr_data,
    output logic             sr_strobe,
    output logic             sr_oe,
    input  logic             sr_miso
);

    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        STROBE,
        DONE
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    div_q;
    logic [BW-1:0]    bit_q;
    logic [NBITS-1:0] shreg_q;
    logic [NBITS-1:0] cap_q;
    logic [NBITS-1:0] rdata_q;
    logic             busy_q;
    logic             done_q;
    logic             sr_clk_q;
    logic             sr_data_q;
    logic             sr_strobe_q;
    logic             sr_oe_q;

    logic             div_last;
    logic [BW-1:0]    bit_d;

    assign div_last = (div_q == DW'(DIV - 1));
    assign bit_d    = bit_q + BW'(1);

    // Sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            cap_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sr_clk_q    <= 1'b0;
            sr_data_q   <= 1'b0;
            sr_strobe_q <= 1'b0;
            sr_oe_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= data;
                        cap_q     <= '0;
                        div_q     <= '0;
                        bit_q     <= '0;
                        busy_q    <= 1'b1;
                        sr_clk_q  <= 1'b0;
                        sr_data_q <= data[NBITS-1];
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_q    <= '0;
                        sr_clk_q <= 1'b1;
                        // The chain has not shifted yet: this is its old MSB.
                        cap_q    <= {cap_q[NBITS-2:0], sr_miso};
                        state_q  <= SHIFT_HI;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_q    <= '0;
                        sr_clk_q <= 1'b0;
                        bit_q    <= bit_d;
                        if (bit_d < BW'(NBITS)) begin
                            shreg_q   <= {shreg_q[NBITS-2:0], 1'b0};
                            sr_data_q <= shreg_q[NBITS-2];
                            state_q   <= SHIFT_LO;
                        end else begin
                            sr_data_q   <= 1'b0;
                            sr_strobe_q <= 1'b1;
                            state_q     <= STROBE;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                STROBE: begin
                    if (div_last) begin
                        div_q       <= '0;
                        bit_q       <= '0;
                        sr_strobe_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        rdata_q     <= cap_q;
                        sr_oe_q     <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign sr_clk    = sr_clk_q;
    assign sr_data   = sr_data_q;
    assign sr_strobe = sr_strobe_q;
    assign sr_oe     = sr_oe_q;

endmodule

// File: tb/tb_sr4094_loader.sv
// tb_sr4094_loader: directed + random loads of an 8-bit chain (DIV=2),
// with a 4094 chain/latch emulation feeding sr_miso.
module tb_sr4094_loader;

    localparam int NB = 8;
    localparam int DV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NB-1:0] data = '0;
    logic          busy, done, sr_clk, sr_data, sr_strobe, sr_oe, sr_miso;
    logic [NB-1:0] rdata;

    int vectors = 0;
    int miscompares = 0;

    // Chain emulation state
    logic          pre = 1'b0;
    logic [NB-1:0] pre_val = '0;
    logic [NB-1:0] chain = '0;
    logic [NB-1:0] latch = '0;
    logic          clk_prev = 1'b0;

    // Reference expectations
    logic [NB-1:0] exp_chain;
    logic [NB-1:0] exp_latch;
    logic          exp_oe;

    sr4094_loader #(.NBITS(NB), .DIV(DV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .sr_clk    (sr_clk),
        .sr_data   (sr_data),
        .sr_strobe (sr_strobe),
        .sr_oe     (sr_oe),
        .sr_miso   (sr_miso)
    );

    always #5 clk = ~clk;

    // 4094 chain: shift on sr_clk rise, latch while strobe is high.
    always @(posedge clk) begin
        clk_prev <= sr_clk;
        if (pre) chain <= pre_val;
        else if (sr_clk && !clk_prev) chain <= {chain[NB-2:0], sr_data};
        if (sr_strobe) latch <= chain;
    end

    assign sr_miso = chain[NB-1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".sr_clk"}, 64'(sr_clk), 64'd0);
        chk({tag, ".sr_data"}, 64'(sr_data), 64'd0);
        chk({tag, ".sr_strobe"}, 64'(sr_strobe), 64'd0);
        chk({tag, ".sr_oe"}, 64'(sr_oe), 64'd0);
        chk({tag, ".rdata"}, 64'(rdata), 64'd0);
    endtask

    // One load, observed cycle by cycle at the falling edge.
    task automatic run_load(input logic [NB-1:0] d, input bit chg,
                            input bit extra, input int rst_at);
        logic [NB-1:0] seq;
        logic          pclk, hold, oe1, oe_dn;
        logic [NB-1:0] rd;
        int rises, hi, bsy, stb, dn, post, unstable, dirty;
        bit aborted;
        seq = '0; pclk = 0; hold = 0; oe1 = 0; oe_dn = 0; rd = '0;
        rises = 0; hi = 0; bsy = 0; stb = 0; dn = 0; post = 0;
        unstable = 0; dirty = 0; aborted = 0;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        if (chg) data = ~d;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            if (cyc == 1) oe1 = sr_oe;
            if (busy) bsy++;
            if (sr_clk && !pclk) begin
                seq = {seq[NB-2:0], sr_data};
                hold = sr_data;
                rises++;
            end
            if (sr_clk) begin
                hi++;
                if (sr_data !== hold) unstable++;
            end
            if (sr_strobe) stb++;
            if ((sr_strobe || !busy) && sr_data) dirty++;
            if (done) begin
                dn++;
                rd = rdata;
                oe_dn = sr_oe;
            end
            pclk = sr_clk;
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset_outs("abort");
                aborted = 1;
                break;
            end
            start = extra && (cyc == 5 || cyc == 20 || done);
            if (dn > 0) post++;
            if (post == 4) break;
            @(negedge clk);
        end
        start = 1'b0;
        data  = '0;
        chk("oe_at_start", 64'(oe1), 64'(exp_oe));
        if (aborted) begin
            chk("abort.rises", 64'(rises), 64'd2);
            chk("abort.strobe", 64'(stb), 64'd0);
            chk("abort.done", 64'(dn), 64'd0);
            @(negedge clk);
            chk("abort.latch", 64'(latch), 64'(exp_latch));
            exp_chain = (exp_chain << 2) | (d >> (NB - 2));
            exp_oe = 1'b0;
        end else begin
            chk("seq", 64'(seq), 64'(d));
            chk("rises", 64'(rises), 64'(NB));
            chk("hi_cycles", 64'(hi), 64'(NB * DV));
            chk("busy_cycles", 64'(bsy), 64'(2 * DV * NB + DV));
            chk("strobe_cycles", 64'(stb), 64'(DV));
            chk("done_pulses", 64'(dn), 64'd1);
            chk("rdata", 64'(rd), 64'(exp_chain));
            chk("oe_at_done", 64'(oe_dn), 64'd1);
            chk("data_stable", 64'(unstable), 64'd0);
            chk("data_zero", 64'(dirty), 64'd0);
            chk("latch", 64'(latch), 64'(d));
            exp_chain = d;
            exp_latch = d;
            exp_oe = 1'b1;
        end
    endtask

    initial begin
        exp_chain = 8'h3C;
        exp_latch = '0;
        exp_oe    = 1'b0;
        rst     = 1'b1;
        pre     = 1'b1;
        pre_val = 8'h3C;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        pre = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        run_load(8'hFF, 0, 0, -1);
        run_load(8'h00, 0, 0, -1);
        run_load(8'hA5, 0, 1, -1);
        run_load(8'hA5, 1, 0, -1);
        run_load(8'($urandom), 0, 0, 10);
        run_load(8'h81, 0, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_load(8'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
